// File: rtl/cpu_ctrl_sequencer.sv
// Multi-cycle FETCH/EXEC/HALT control sequencer for the 16-bit CPU: owns PC, IR and the
// one-bit microstep register, gates decoder write strobes and records sticky error flags.
module cpu_ctrl_sequencer #(
  parameter int          PC_W    = 16,
  parameter int          MEM_TO  = 15,
  parameter logic [6:0]  HALT_OP = 7'b1111111
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_read,
  input  logic [15:0]     mem_rdata,
  input  logic            mem_ready,
  output logic [15:0]     IR,
  output logic            State,
  output logic [PC_W-1:0] PC,
  input  logic [1:0]      dec_PS,
  input  logic            dec_NS,
  input  logic            dec_WR,
  input  logic            dec_MemWrite,
  input  logic [PC_W-1:0] br_offset,
  input  logic [PC_W-1:0] jmp_addr,
  output logic            WR_g,
  output logic            MemWrite_g,
  output logic            halted,
  output logic [1:0]      err,
  output logic [15:0]     retired
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q;
  logic            step_q;
  logic [7:0]      cnt_q;
  logic [1:0]      err_q;
  logic [15:0]     ret_q;
  logic            halted_q;

  logic            xfer_ok;
  logic            last_step;
  logic            cnt_to;

  // An EXEC cycle only takes effect once any pending store has been accepted.
  assign xfer_ok   = !dec_MemWrite || mem_ready;
  assign last_step = !(dec_NS && !step_q);
  assign cnt_to    = (cnt_q == 8'(MEM_TO));

  always_comb begin
    pc_d = pc_q;
    case (dec_PS)
      2'b00:   pc_d = pc_q;
      2'b01:   pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      2'b10:   pc_d = pc_q + br_offset;
      default: pc_d = jmp_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      step_q   <= 1'b0;
      cnt_q    <= '0;
      err_q    <= '0;
      ret_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) begin
            ir_q   <= mem_rdata;
            step_q <= 1'b0;
            cnt_q  <= '0;
            if (mem_rdata[15:9] == HALT_OP) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= S_EXEC;
            end
          end else if (cnt_to) begin
            err_q[0] <= 1'b1;
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_EXEC: begin
          if (xfer_ok) begin
            cnt_q <= '0;
            if (!last_step) begin
              step_q <= 1'b1;
            end else begin
              // NS requested on the last microstep is an overflow; the instruction still retires.
              if (dec_NS) err_q[1] <= 1'b1;
              pc_q    <= pc_d;
              step_q  <= 1'b0;
              ret_q   <= ret_q + 16'd1;
              state_q <= S_FETCH;
            end
          end else if (cnt_to) begin
            err_q[0] <= 1'b1;
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_read   = (state_q == S_FETCH);
  assign mem_addr   = pc_q;
  assign WR_g       = (state_q == S_EXEC) && dec_WR && xfer_ok;
  assign MemWrite_g = (state_q == S_EXEC) && dec_MemWrite;
  assign IR         = ir_q;
  assign State      = step_q;
  assign PC         = pc_q;
  assign halted     = halted_q;
  assign err        = err_q;
  assign retired    = ret_q;

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Table-driven bench for cpu_ctrl_sequencer, with a second short-timeout instance
// exercised by hand-written bus-timeout sequences.
module tb_cpu_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [1:0]  dec_PS;
  logic        dec_NS, dec_WR, dec_MemWrite;
  logic [15:0] br_offset, jmp_addr;

  logic [15:0] mem_addr, IR, PC, retired;
  logic        mem_read, State, WR_g, MemWrite_g, halted;
  logic [1:0]  err;

  logic [15:0] mem_addr_t, IR_t, PC_t, retired_t;
  logic        mem_read_t, State_t, WR_g_t, MemWrite_g_t, halted_t;
  logic [1:0]  err_t;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_ctrl_sequencer #(.PC_W(16), .MEM_TO(15), .HALT_OP(7'b1111111)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .IR(IR), .State(State), .PC(PC),
    .dec_PS(dec_PS), .dec_NS(dec_NS), .dec_WR(dec_WR), .dec_MemWrite(dec_MemWrite),
    .br_offset(br_offset), .jmp_addr(jmp_addr), .WR_g(WR_g), .MemWrite_g(MemWrite_g),
    .halted(halted), .err(err), .retired(retired)
  );

  cpu_ctrl_sequencer #(.PC_W(16), .MEM_TO(2), .HALT_OP(7'b1111111)) dut_to (
    .clk(clk), .rst(rst), .mem_addr(mem_addr_t), .mem_read(mem_read_t),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .IR(IR_t), .State(State_t), .PC(PC_t),
    .dec_PS(dec_PS), .dec_NS(dec_NS), .dec_WR(dec_WR), .dec_MemWrite(dec_MemWrite),
    .br_offset(br_offset), .jmp_addr(jmp_addr), .WR_g(WR_g_t), .MemWrite_g(MemWrite_g_t),
    .halted(halted_t), .err(err_t), .retired(retired_t)
  );

  typedef struct {
    logic        r, rdy;
    logic [15:0] rd;
    logic [1:0]  ps;
    logic        ns, wr, mw;
    logic [15:0] bro, jmp;
    logic [2:0]  c;      // expected {mem_read, WR_g, MemWrite_g} before the edge
    logic [15:0] pc, ir;
    logic        st, h;
    logic [1:0]  er;
    logic [15:0] rt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic rdy, logic [15:0] rd, logic [1:0] ps,
                              logic ns, logic wr, logic mw, logic [15:0] bro,
                              logic [15:0] jmp, logic [2:0] c, logic [15:0] pc,
                              logic [15:0] ir, logic st, logic h, logic [1:0] er,
                              logic [15:0] rt);
    vec_t v;
    v.r = r; v.rdy = rdy; v.rd = rd; v.ps = ps; v.ns = ns; v.wr = wr; v.mw = mw;
    v.bro = bro; v.jmp = jmp; v.c = c; v.pc = pc; v.ir = ir; v.st = st; v.h = h;
    v.er = er; v.rt = rt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic [15:0] rd,
                       input logic [1:0] ps, input logic ns, input logic wr, input logic mw,
                       input logic [15:0] bro, input logic [15:0] jmp);
    rst = r; mem_ready = rdy; mem_rdata = rd; dec_PS = ps; dec_NS = ns;
    dec_WR = wr; dec_MemWrite = mw; br_offset = bro; jmp_addr = jmp;
  endtask

  task automatic run_vec(input vec_t v, input int i, input logic [15:0] prev_pc);
    drive(v.r, v.rdy, v.rd, v.ps, v.ns, v.wr, v.mw, v.bro, v.jmp);
    #3;
    chk($sformatf("v%0d comb", i), 16'({mem_read, WR_g, MemWrite_g}), 16'(v.c));
    chk($sformatf("v%0d mem_addr", i), mem_addr, prev_pc);
    @(posedge clk); #1;
    chk($sformatf("v%0d PC", i), PC, v.pc);
    chk($sformatf("v%0d IR", i), IR, v.ir);
    chk($sformatf("v%0d State", i), 16'(State), 16'(v.st));
    chk($sformatf("v%0d halted", i), 16'(halted), 16'(v.h));
    chk($sformatf("v%0d err", i), 16'(err), 16'(v.er));
    chk($sformatf("v%0d retired", i), retired, v.rt);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] last_pc;
    //          r  rdy rdata     ps    ns wr mw bro       jmp       c       pc        ir       st h  er     rt
    vq.push_back(mk(0, 1, 16'h1805, 2'b01, 0, 1, 0, 16'h0000, 16'h0000, 3'b100, 16'h0000, 16'h1805, 0, 0, 2'b00, 16'd0));
    vq.push_back(mk(0, 1, 16'h0000, 2'b01, 0, 1, 0, 16'h0000, 16'h0000, 3'b010, 16'h0001, 16'h1805, 0, 0, 2'b00, 16'd1));
    vq.push_back(mk(0, 1, 16'h2000, 2'b01, 0, 1, 0, 16'h0000, 16'h0000, 3'b100, 16'h0001, 16'h2000, 0, 0, 2'b00, 16'd1));
    vq.push_back(mk(0, 1, 16'h0000, 2'b11, 0, 0, 0, 16'h0000, 16'h0004, 3'b000, 16'h0004, 16'h2000, 0, 0, 2'b00, 16'd2));
    vq.push_back(mk(0, 1, 16'h3000, 2'b00, 0, 0, 0, 16'h0000, 16'h0000, 3'b100, 16'h0004, 16'h3000, 0, 0, 2'b00, 16'd2));
    vq.push_back(mk(0, 0, 16'h0000, 2'b01, 1, 1, 0, 16'h0000, 16'h0000, 3'b010, 16'h0004, 16'h3000, 1, 0, 2'b00, 16'd2));
    vq.push_back(mk(0, 0, 16'h0000, 2'b10, 0, 1, 0, 16'hFFFE, 16'h0000, 3'b010, 16'h0002, 16'h3000, 0, 0, 2'b00, 16'd3));
    vq.push_back(mk(0, 1, 16'h4000, 2'b00, 0, 0, 0, 16'h0000, 16'h0000, 3'b100, 16'h0002, 16'h4000, 0, 0, 2'b00, 16'd3));
    for (int k = 0; k < 3; k++)
      vq.push_back(mk(0, 0, 16'h0000, 2'b01, 0, 1, 1, 16'h0000, 16'h0000, 3'b001, 16'h0002, 16'h4000, 0, 0, 2'b00, 16'd3));
    vq.push_back(mk(0, 1, 16'h0000, 2'b01, 0, 1, 1, 16'h0000, 16'h0000, 3'b011, 16'h0003, 16'h4000, 0, 0, 2'b00, 16'd4));
    vq.push_back(mk(0, 1, 16'h5000, 2'b00, 0, 0, 0, 16'h0000, 16'h0000, 3'b100, 16'h0003, 16'h5000, 0, 0, 2'b00, 16'd4));
    vq.push_back(mk(0, 1, 16'h0000, 2'b11, 0, 0, 0, 16'h0000, 16'hFFFF, 3'b000, 16'hFFFF, 16'h5000, 0, 0, 2'b00, 16'd5));
    vq.push_back(mk(0, 1, 16'h5001, 2'b00, 0, 0, 0, 16'h0000, 16'h0000, 3'b100, 16'hFFFF, 16'h5001, 0, 0, 2'b00, 16'd5));
    vq.push_back(mk(0, 1, 16'h0000, 2'b01, 0, 0, 0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h5001, 0, 0, 2'b00, 16'd6));
    vq.push_back(mk(0, 1, 16'h5002, 2'b00, 0, 0, 0, 16'h0000, 16'h0000, 3'b100, 16'h0000, 16'h5002, 0, 0, 2'b00, 16'd6));
    vq.push_back(mk(0, 1, 16'h0000, 2'b11, 0, 0, 0, 16'h0000, 16'h0040, 3'b000, 16'h0040, 16'h5002, 0, 0, 2'b00, 16'd7));
    vq.push_back(mk(0, 1, 16'h6000, 2'b00, 0, 0, 0, 16'h0000, 16'h0000, 3'b100, 16'h0040, 16'h6000, 0, 0, 2'b00, 16'd7));
    vq.push_back(mk(0, 1, 16'h0000, 2'b00, 1, 1, 0, 16'h0000, 16'h0000, 3'b010, 16'h0040, 16'h6000, 1, 0, 2'b00, 16'd7));
    vq.push_back(mk(0, 1, 16'h0000, 2'b01, 1, 1, 0, 16'h0000, 16'h0000, 3'b010, 16'h0041, 16'h6000, 0, 0, 2'b10, 16'd8));
    vq.push_back(mk(0, 1, 16'h6001, 2'b00, 0, 0, 0, 16'h0000, 16'h0000, 3'b100, 16'h0041, 16'h6001, 0, 0, 2'b10, 16'd8));
    vq.push_back(mk(0, 1, 16'h0000, 2'b01, 0, 0, 0, 16'h0000, 16'h0000, 3'b000, 16'h0042, 16'h6001, 0, 0, 2'b10, 16'd9));
    vq.push_back(mk(0, 1, 16'hFE00, 2'b01, 0, 1, 0, 16'h0000, 16'h0000, 3'b100, 16'h0042, 16'hFE00, 0, 1, 2'b10, 16'd9));
    for (int k = 0; k < 2; k++)
      vq.push_back(mk(0, 1, 16'h1234, 2'b01, 0, 1, 1, 16'h0000, 16'h0000, 3'b000, 16'h0042, 16'hFE00, 0, 1, 2'b10, 16'd9));
    vq.push_back(mk(1, 1, 16'h1234, 2'b01, 0, 1, 1, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000, 0, 0, 2'b00, 16'd0));
    vq.push_back(mk(0, 1, 16'h7000, 2'b00, 0, 0, 0, 16'h0000, 16'h0000, 3'b100, 16'h0000, 16'h7000, 0, 0, 2'b00, 16'd0));
    vq.push_back(mk(0, 1, 16'h0000, 2'b01, 0, 0, 0, 16'h0000, 16'h0000, 3'b000, 16'h0001, 16'h7000, 0, 0, 2'b00, 16'd1));
    vq.push_back(mk(0, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000, 16'h0000, 3'b100, 16'h0001, 16'h7000, 0, 0, 2'b00, 16'd1));
    vq.push_back(mk(1, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000, 16'h0000, 3'b100, 16'h0000, 16'h0000, 0, 0, 2'b00, 16'd0));
    vq.push_back(mk(0, 1, 16'h1805, 2'b00, 0, 0, 0, 16'h0000, 16'h0000, 3'b100, 16'h0000, 16'h1805, 0, 0, 2'b00, 16'd0));
    vq.push_back(mk(0, 0, 16'h0000, 2'b01, 0, 1, 1, 16'h0000, 16'h0000, 3'b001, 16'h0000, 16'h1805, 0, 0, 2'b00, 16'd0));
    vq.push_back(mk(1, 0, 16'h0000, 2'b01, 0, 1, 1, 16'h0000, 16'h0000, 3'b001, 16'h0000, 16'h0000, 0, 0, 2'b00, 16'd0));
    vq.push_back(mk(0, 1, 16'h0001, 2'b01, 0, 1, 0, 16'h0000, 16'h0000, 3'b100, 16'h0000, 16'h0001, 0, 0, 2'b00, 16'd0));

    drive(1, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000, 16'h0000);
    @(posedge clk); tick();
    chk("rst PC", PC, 16'h0000);
    chk("rst IR", IR, 16'h0000);
    chk("rst State/halted/err", 16'({State, halted, err}), 16'h0000);
    chk("rst retired", retired, 16'h0000);
    chk("rst mem_read", 16'(mem_read), 16'h0001);

    last_pc = 16'h0000;
    foreach (vq[i]) begin
      run_vec(vq[i], i, last_pc);
      last_pc = vq[i].pc;
    end

    // Store timeout: MEM_TO=2 instance gives up after three unanswered cycles.
    drive(1, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000, 16'h0000);
    tick();
    drive(0, 1, 16'h4000, 2'b00, 0, 0, 0, 16'h0000, 16'h0000);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 16'h0000, 2'b01, 0, 1, 1, 16'h0000, 16'h0000);
      #3;
      chk($sformatf("to MemWrite_g c%0d", k), 16'(MemWrite_g_t), 16'h0001);
      chk($sformatf("to WR_g c%0d", k), 16'(WR_g_t), 16'h0000);
      tick();
    end
    chk("to err", 16'(err_t), 16'h0001);
    chk("to halted", 16'(halted_t), 16'h0001);
    chk("to MemWrite_g drop", 16'(MemWrite_g_t), 16'h0000);
    chk("to PC held", PC_t, 16'h0000);
    chk("long-timeout still waiting", 16'({halted, err}), 16'h0000);
    chk("long-timeout MemWrite_g", 16'(MemWrite_g), 16'h0001);

    // Fetch timeout on the short-timeout instance.
    drive(1, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000, 16'h0000);
    tick();
    drive(0, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000, 16'h0000);
    tick(); tick();
    chk("fetch-to not yet", 16'({halted_t, err_t}), 16'h0000);
    tick();
    chk("fetch-to err", 16'(err_t), 16'h0001);
    chk("fetch-to halted", 16'(halted_t), 16'h0001);
    chk("fetch-to mem_read", 16'(mem_read_t), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
